// File: rtl/mealy_pkg.sv
// mealy_pkg
// Shared definitions for the Mealy detector and its downstream bit packer:
//   - packer_state_t : packer FSM states (IDLE, FILL)
//   - det_state_t    : five-state detector encodings, kept here so both
//                      stages use the same source
//   - DEF_WIDTH / DEF_DEPTH : default word width and FIFO depth
package mealy_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } packer_state_t;

  typedef enum logic [2:0] {
    DET_S0 = 3'd0,
    DET_S1 = 3'd1,
    DET_S2 = 3'd2,
    DET_S3 = 3'd3,
    DET_S4 = 3'd4
  } det_state_t;

endpackage

// File: rtl/mealy_sync_fifo.sv
// mealy_sync_fifo
// Synchronous FIFO with registered storage. Full/empty come from the
// occupancy counter, so pointers simply wrap modulo DEPTH.
// Ports:
//   clk_i, reset_i (sync, active-high), clear_i (sync flush)
//   push_i / data_i  : write request; taken when not full or when a pop
//                      happens on the same edge
//   pop_i            : read request; taken only when not empty
//   data_o           : head entry
//   level_o          : occupancy, full_o / empty_o status
module mealy_sync_fifo
  import mealy_pkg::*;
#(
  parameter int DW    = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic w_pop;
  logic w_push;

  assign full_o  = (r_level == LW'(DEPTH));
  assign empty_o = (r_level == '0);
  assign w_pop   = pop_i && !empty_o;
  // A pop on the same edge frees the slot the push needs.
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign level_o = r_level;

endmodule

// File: rtl/mealy_bit_packer.sv
// mealy_bit_packer
// Packs the detector's serial data_out stream into WIDTH-bit words (first
// bit lands in the MSB) and queues them in a DEPTH-entry FIFO presented
// over valid/ready. A completed word that finds the FIFO full (with no pop
// on the same edge) is dropped and sets the sticky overflow flag.
// Ports:
//   clk_i, reset_i (sync, active-high), clear_i (sync flush)
//   bit_i / bit_valid_i        : serial input
//   word_o / word_valid_o / word_ready_i : output handshake
//   fill_o   : bits held in the partial word
//   level_o  : FIFO occupancy
//   overflow_o : sticky word-dropped flag
//   parity_o : even parity of word_o (only with MEALY_BIT_PACKER_PARITY_EN)
// Optional feature macro: MEALY_BIT_PACKER_PARITY_EN
//
// state | meaning
// IDLE  | no bits held, fill = 0
// FILL  | partial word, 0 < fill < WIDTH
module mealy_bit_packer
  import mealy_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int FW   = $clog2(WIDTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic [FW-1:0]    fill_o,
  output logic [LW-1:0]    level_o,
`ifdef MEALY_BIT_PACKER_PARITY_EN
  output logic             parity_o,
`endif
  output logic             overflow_o
);

`ifdef MEALY_BIT_PACKER_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  packer_state_t    r_state, w_state_nxt;
  logic [WIDTH-2:0] r_shreg, w_shreg_nxt;
  logic [FW-1:0]    r_fill, w_fill_nxt;
  logic             r_overflow;

  logic [WIDTH-1:0] w_shift;
  logic             w_push_req;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  logic [EW-1:0]    w_entry_in;
  logic [EW-1:0]    w_entry_out;

  assign w_shift = {r_shreg, bit_i};

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_fill_nxt  = r_fill;
    w_push_req  = 1'b0;
    if (bit_valid_i) begin
      w_shreg_nxt = w_shift[WIDTH-2:0];
      case (r_state)
        IDLE: begin
          w_fill_nxt  = FW'(1);
          w_state_nxt = FILL;
        end
        FILL: begin
          if (r_fill == FW'(WIDTH - 1)) begin
            w_push_req  = 1'b1;
            w_fill_nxt  = '0;
            w_state_nxt = IDLE;
          end else begin
            w_fill_nxt  = r_fill + FW'(1);
            w_state_nxt = FILL;
          end
        end
        default: begin
          w_fill_nxt  = '0;
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Full FIFO still accepts when the consumer pops on the same edge.
  assign w_drop = w_push_req && w_full && !(word_ready_i && !w_empty);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_fill  <= w_fill_nxt;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef MEALY_BIT_PACKER_PARITY_EN
  assign w_entry_in = {^w_shift, w_shift};
  assign parity_o   = w_entry_out[WIDTH];
`else
  assign w_entry_in = w_shift;
`endif

  mealy_sync_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (clear_i),
    .push_i  (w_push_req),
    .data_i  (w_entry_in),
    .pop_i   (word_ready_i),
    .data_o  (w_entry_out),
    .level_o (level_o),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign word_o       = w_entry_out[WIDTH-1:0];
  assign word_valid_o = !w_empty;
  assign fill_o       = r_fill;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_mealy_bit_packer.sv
module tb_mealy_bit_packer;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       bit_i = 1'b0;
  logic       bit_valid_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [7:0] word_o;
  logic       word_valid_o;
  logic       word_ready_i = 1'b0;
  logic [2:0] fill_o;
  logic [2:0] level_o;
  logic       overflow_o;
`ifdef MEALY_BIT_PACKER_PARITY_EN
  logic       parity_o;
`endif

  int checks = 0;
  int failures = 0;

  // Scoreboard and reference model state.
  logic [7:0] exp_q[$];
  logic [7:0] m_sh;
  int         m_fill;
  int         m_level;
  logic       m_ovf;

  always #5 clk_i = ~clk_i;

  mealy_bit_packer #(.WIDTH(8), .DEPTH(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .bit_i        (bit_i),
    .bit_valid_i  (bit_valid_i),
    .clear_i      (clear_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .fill_o       (fill_o),
    .level_o      (level_o),
`ifdef MEALY_BIT_PACKER_PARITY_EN
    .parity_o     (parity_o),
`endif
    .overflow_o   (overflow_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sh = '0;
    m_fill = 0;
    m_level = 0;
    m_ovf = 1'b0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, update the model, check outputs #1 after the edge.
  task automatic cyc(input logic bv, input logic b, input logic rdy,
                     input logic clr, input logic rst);
    logic pop;
    logic [7:0] w;
    bit_valid_i  = bv;
    bit_i        = b;
    word_ready_i = rdy;
    clear_i      = clr;
    reset_i      = rst;
    #1;
    pop = (m_level > 0) && rdy && !clr && !rst;
    if (pop) begin
      w = exp_q.pop_front();
      check("pop_word", {24'd0, word_o}, {24'd0, w});
`ifdef MEALY_BIT_PACKER_PARITY_EN
      check("pop_parity", {31'd0, parity_o}, {31'd0, ^w});
`endif
      m_level--;
    end
    if (rst || clr) begin
      model_reset();
    end else if (bv) begin
      m_sh = {m_sh[6:0], b};
      if (m_fill == 7) begin
        m_fill = 0;
        if (m_level < 4 || pop) begin
          exp_q.push_back(m_sh);
          m_level++;
        end else begin
          m_ovf = 1'b1;
        end
      end else begin
        m_fill++;
      end
    end
    @(posedge clk_i);
    #1;
    check("fill", {29'd0, fill_o}, m_fill);
    check("level", {29'd0, level_o}, m_level);
    check("valid", {31'd0, word_valid_o}, {31'd0, (m_level > 0)});
    check("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy, input logic rdy_last,
                           input logic gap);
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b1, b[i], (i == 0) ? rdy_last : rdy, 1'b0, 1'b0);
      if (gap && i != 0) cyc(1'b0, ~b[i], rdy, 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    // Reset then idle with toggling bit_i.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_word", {24'd0, word_o}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, i[0], 1'b0, 1'b0, 1'b0);
      check("idle_word", {24'd0, word_o}, 32'd0);
    end
`ifdef MEALY_BIT_PACKER_PARITY_EN
    check("idle_parity", {31'd0, parity_o}, 32'd0);
`endif

    // Consecutive bits -> 0xB2 one cycle after the 8th bit.
    send_byte(8'hB2, 1'b1, 1'b1, 1'b0);
    check("b2_word", {24'd0, word_o}, 32'hB2);
    check("b2_valid", {31'd0, word_valid_o}, 32'd1);
`ifdef MEALY_BIT_PACKER_PARITY_EN
    check("b2_parity", {31'd0, parity_o}, 32'd0);
`endif
    drain();

    // Gapped input, fill checked by the model every cycle.
    send_byte(8'hB2, 1'b0, 1'b0, 1'b1);
    check("gap_word", {24'd0, word_o}, 32'hB2);
    drain();

    // Five words with ready low: fifth dropped.
    send_byte(8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0, 1'b0);
    check("ovf_level", {29'd0, level_o}, 32'd4);
    check("ovf_flag", {31'd0, overflow_o}, 32'd1);
    check("ovf_head", {24'd0, word_o}, 32'h11);
    drain();
    check("ovf_sticky", {31'd0, overflow_o}, 32'd1);

    // Full FIFO with a pop on the completing edge: no overflow.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b1, 1'b0);
    check("pp_level", {29'd0, level_o}, 32'd4);
    check("pp_ovf", {31'd0, overflow_o}, 32'd0);
    check("pp_head", {24'd0, word_o}, 32'h02);
    drain();

    // Clear mid-word, then a fresh word.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("clr_fill", {29'd0, fill_o}, 32'd0);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    check("clr_word", {24'd0, word_o}, 32'hA5);
    drain();

    // Same with reset mid-word.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_fill", {29'd0, fill_o}, 32'd0);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b0);
    check("rst_word2", {24'd0, word_o}, 32'hA5);
    drain();
    check("final_q", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
